sha256crypt_cfg_sequencer: RTL

- Controls the CMP_CONFIG handoff between the cmp_config packet parser and the sha256crypt core array.
- On `new_cmp_config` it stops new work dispatch and waits for all cores to drain.
- It then copies salt, salt_len and iteration count from the parser's asynchronous config DRAM into committed registers and pulses `cmp_config_applied` to release the parser.
- Cores only ever see a config that is stable and has been applied atomically.

---
 rtl/sha256crypt_pkg.sv | 31 +++
 rtl/sha256crypt_drain_detect.sv | 37 +++
 rtl/sha256crypt_cfg_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/sha256crypt_pkg.sv
// Purpose: shared FSM encodings, config DRAM map and the staged-config record for the sha256crypt control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha256crypt_pkg;

    // Sequencer states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DRAIN    = 3'd1;
    localparam logic [2:0] ST_COPY     = 3'd2;
    localparam logic [2:0] ST_COMMIT   = 3'd3;
    localparam logic [2:0] ST_WAIT_LOW = 3'd4;

    // Parser config DRAM layout
    localparam logic [4:0] CFG_ITER_BASE = 5'd0;
    localparam logic [4:0] CFG_SALT_LEN  = 5'd4;
    localparam logic [4:0] CFG_SALT_BASE = 5'd8;
    localparam logic [4:0] CFG_LAST      = 5'd23;

    typedef struct packed {
        logic [31:0]  iter;
        logic [4:0]   salt_len;
        logic [127:0] salt;
    } cfg_t;

    // Salt byte index for DRAM addresses 8..23. Only the low address
    // nibble matters: (addr - 8) mod 16 equals addr[3:0] - 8 mod 16.
    function automatic logic [3:0] cfg_salt_idx(input logic [3:0] addr_lo);
        return addr_lo - 4'(CFG_SALT_BASE);
    endfunction

endpackage

// File: rtl/sha256crypt_drain_detect.sv
// Purpose: counts consecutive all-idle cycles of the core array; drained fires on the DRAIN_CYCLES-th one.
// Latency: drained is combinational on the cycle that completes the run; counter clears whenever en drops or a core is busy.
// Backpressure: none; the caller holds en for as long as it is willing to wait (no timeout).
// Ports: CLK/RST_N clock and async active-low reset; en arms the counter; core_idle per-core idle flags; drained run complete.
module sha256crypt_drain_detect #(
    parameter int N_CORES      = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               en,
    input  logic [N_CORES-1:0] core_idle,
    output logic               drained
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    logic [CNT_W-1:0] drain_cnt;
    logic             all_idle;

    assign all_idle = &core_idle;
    assign drained  = en & all_idle & (drain_cnt == CNT_LAST);

    // Any busy core restarts the run; the count also resets once it has
    // fired so a re-armed detector starts from zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drain_cnt <= '0;
        end else if (!en || !all_idle || drained) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sha256crypt_cfg_sequencer.sv
// Purpose: gates dispatch, drains the cores, copies the pending CMP_CONFIG from the parser DRAM and commits it atomically.
// Latency: new_cmp_config to cmp_config_applied = 1 + DRAIN_CYCLES + 24 + 1 cycles with all cores idle.
// Backpressure: waits indefinitely for the core array to drain; holds off re-arming until the parser drops new_cmp_config.
// Ports: CLK/RST_N; new_cmp_config/cmp_config_applied parser handshake; cfg_addr/cfg_dout async DRAM read;
//        core_idle per-core flags; dispatch_en; committed iter_count, salt_len, salt, cfg_valid, cfg_err, cfg_epoch.
module sha256crypt_cfg_sequencer
    import sha256crypt_pkg::*;
#(
    parameter int N_CORES      = 8,
    parameter int DRAIN_CYCLES = 2,
    parameter int EPOCH_W      = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               new_cmp_config,
    output logic               cmp_config_applied,
    output logic [4:0]         cfg_addr,
    input  logic [7:0]         cfg_dout,
    input  logic [N_CORES-1:0] core_idle,
    output logic               dispatch_en,
    output logic [31:0]        iter_count,
    output logic [4:0]         salt_len,
    output logic [127:0]       salt,
    output logic               cfg_valid,
    output logic               cfg_err,
    output logic [EPOCH_W-1:0] cfg_epoch
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [4:0] copy_addr;
    cfg_t       stage;
    logic       drained;
    logic       stage_ok;

    sha256crypt_drain_detect #(
        .N_CORES      (N_CORES),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_drain (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .en        (state == ST_DRAIN),
        .core_idle (core_idle),
        .drained   (drained)
    );

    assign cfg_addr = (state == ST_COPY) ? copy_addr : 5'd0;
    assign stage_ok = (stage.iter != 32'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (new_cmp_config)        state_nxt = ST_DRAIN;
            ST_DRAIN:    if (drained)               state_nxt = ST_COPY;
            ST_COPY:     if (copy_addr == CFG_LAST) state_nxt = ST_COMMIT;
            ST_COMMIT:                              state_nxt = ST_WAIT_LOW;
            // The parser drops its level one cycle after the pulse; waiting
            // here keeps the stale level from starting a second sequence.
            ST_WAIT_LOW: if (!new_cmp_config)       state_nxt = ST_IDLE;
            default:                                state_nxt = ST_IDLE;
        endcase
    end

    // FSM, copy address and staging capture
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            copy_addr <= 5'd0;
            stage     <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_COPY) begin
                copy_addr <= copy_addr + 5'd1;
                if (copy_addr < CFG_SALT_LEN) begin
                    stage.iter[{copy_addr[1:0], 3'b000} +: 8] <= cfg_dout;
                end else if (copy_addr == CFG_SALT_LEN) begin
                    stage.salt_len <= cfg_dout[4:0];
                end else if (copy_addr >= CFG_SALT_BASE) begin
                    stage.salt[{cfg_salt_idx(copy_addr[3:0]), 3'b000} +: 8] <= cfg_dout;
                end
                // Addresses 5..7 are reserved in the DRAM map and dropped.
            end else begin
                copy_addr <= 5'd0;
            end
        end
    end

    // Committed config: written only on the COMMIT edge, so the cores
    // see either the old config or the new one, never a mix.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cmp_config_applied <= 1'b0;
            iter_count         <= 32'd0;
            salt_len           <= 5'd0;
            salt               <= 128'd0;
            cfg_valid          <= 1'b0;
            cfg_err            <= 1'b0;
            cfg_epoch          <= '0;
            dispatch_en        <= 1'b0;
        end else begin
            cmp_config_applied <= (state == ST_COMMIT);
            if (state == ST_COMMIT) begin
                iter_count <= stage.iter;
                salt_len   <= stage.salt_len;
                salt       <= stage.salt;
                cfg_valid  <= stage_ok;
                cfg_err    <= ~stage_ok;
                cfg_epoch  <= cfg_epoch + EPOCH_W'(1);
            end
            // Built from the next state so dispatch stops on the same edge
            // that leaves IDLE. COMMIT never goes straight to IDLE, so the
            // current cfg_valid is the right qualifier here.
            dispatch_en <= cfg_valid & (state_nxt == ST_IDLE);
        end
    end

endmodule
